// File: rtl/median_window3x3.sv
// Streaming 3x3 window generator: two column-addressed line buffers plus a
// column shift register produce zero-padded taps for a downstream median filter.
module median_window3x3 #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 1920,
  parameter int AWIDTH = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] line_width,
  input  logic [AWIDTH-1:0] frame_height,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [WIDTH+1:0]  in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [WIDTH+1:0]  win_1,
  output logic [WIDTH+1:0]  win_2,
  output logic [WIDTH+1:0]  win_3,
  output logic [WIDTH+1:0]  win_4,
  output logic [WIDTH+1:0]  win_5,
  output logic [WIDTH+1:0]  win_6,
  output logic [WIDTH+1:0]  win_7,
  output logic [WIDTH+1:0]  win_8,
  output logic [WIDTH+1:0]  win_9,
  output logic              frame_done
);

  localparam int PW = WIDTH + 2;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [PW-1:0] PAD = {2'b01, {WIDTH{1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [AWIDTH-1:0] w_q, w_d, h_q, h_d;
  logic [AWIDTH-1:0] col_q, col_d, row_q, row_d;
  logic [AWIDTH-1:0] rc_q, rc_d, cc_q, cc_d;
  logic [AWIDTH-1:0] fcnt_q, fcnt_d;
  logic [2:0][1:0][PW-1:0] sr_q, sr_d;
  logic [8:0][PW-1:0] win_q, win_d;
  logic              out_valid_q, out_valid_d;
  logic              frame_done_q, frame_done_d;

  logic [PW-1:0] line_a [DEPTH];
  logic [PW-1:0] line_b [DEPTH];

  logic              idle, step, emit, col_last;
  logic [AWIDTH-1:0] w_cur, h_cur, col_cur, row_cur;
  logic [PW-1:0]     a_rd, b_rd, pix_in;
  logic [2:0][PW-1:0] ncol;
  logic              m_top, m_bot, m_left, m_right;

  assign in_ready = !rst && (state_q != S_FLUSH);

  always_comb begin
    idle    = (state_q == S_IDLE);
    // The sof pixel is processed in the same step that latches W and H.
    w_cur   = idle ? line_width   : w_q;
    h_cur   = idle ? frame_height : h_q;
    col_cur = idle ? '0 : col_q;
    row_cur = idle ? '0 : row_q;
    case (state_q)
      S_IDLE:  step = in_valid && in_sof;
      S_RUN:   step = in_valid;
      S_FLUSH: step = 1'b1;
      default: step = 1'b0;
    endcase
    emit     = step && ((state_q == S_FLUSH) || (row_cur >= AWIDTH'(2)) ||
                        ((row_cur == AWIDTH'(1)) && (col_cur != '0)));
    col_last = (col_cur == w_cur - AWIDTH'(1));
    a_rd     = line_a[col_cur];
    b_rd     = line_b[col_cur];
    pix_in   = (state_q == S_FLUSH) ? PAD : in_data;
    ncol[0]  = b_rd;
    ncol[1]  = a_rd;
    ncol[2]  = pix_in;
    m_top    = (rc_q == '0);
    m_bot    = (rc_q == h_q - AWIDTH'(1));
    m_left   = (cc_q == '0);
    m_right  = (cc_q == w_q - AWIDTH'(1));

    state_d      = state_q;
    w_d          = w_q;
    h_d          = h_q;
    col_d        = col_q;
    row_d        = row_q;
    rc_d         = rc_q;
    cc_d         = cc_q;
    fcnt_d       = fcnt_q;
    sr_d         = sr_q;
    win_d        = win_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;

    if (step) begin
      col_d = col_last ? '0 : col_cur + AWIDTH'(1);
      row_d = col_last ? row_cur + AWIDTH'(1) : row_cur;
      for (int unsigned r = 0; r < 3; r++) begin
        sr_d[r][1] = sr_q[r][0];
        sr_d[r][0] = ncol[r];
      end
      case (state_q)
        S_IDLE: begin
          state_d = S_RUN;
          w_d     = line_width;
          h_d     = frame_height;
          rc_d    = '0;
          cc_d    = '0;
        end
        S_RUN: begin
          if (col_last && (row_cur == h_cur - AWIDTH'(1))) begin
            state_d = S_FLUSH;
            fcnt_d  = '0;
          end
        end
        S_FLUSH: begin
          fcnt_d = fcnt_q + AWIDTH'(1);
          if (fcnt_q == w_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (emit) begin
      out_valid_d  = 1'b1;
      frame_done_d = m_bot && m_right;
      // Tap columns: [1] is c-2 (left), [0] is c-1 (centre), ncol is c (right).
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned k = 0; k < 3; k++) begin
          if ((r == 0 && m_top) || (r == 2 && m_bot) ||
              (k == 0 && m_left) || (k == 2 && m_right))
            win_d[r*3+k] = PAD;
          else if (k == 0)
            win_d[r*3+k] = sr_q[r][1];
          else if (k == 1)
            win_d[r*3+k] = sr_q[r][0];
          else
            win_d[r*3+k] = ncol[r];
        end
      end
      if (m_right) begin
        cc_d = '0;
        rc_d = rc_q + AWIDTH'(1);
      end else begin
        cc_d = cc_q + AWIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      w_q          <= '0;
      h_q          <= '0;
      col_q        <= '0;
      row_q        <= '0;
      rc_q         <= '0;
      cc_q         <= '0;
      fcnt_q       <= '0;
      sr_q         <= '0;
      win_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      w_q          <= w_d;
      h_q          <= h_d;
      col_q        <= col_d;
      row_q        <= row_d;
      rc_q         <= rc_d;
      cc_q         <= cc_d;
      fcnt_q       <= fcnt_d;
      sr_q         <= sr_d;
      win_q        <= win_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Read-before-write: row r-1 moves from A into B as row r enters A.
  always_ff @(posedge clk) begin
    if (step && !rst) begin
      line_a[col_cur] <= pix_in;
      line_b[col_cur] <= a_rd;
    end
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign win_1 = win_q[0];
  assign win_2 = win_q[1];
  assign win_3 = win_q[2];
  assign win_4 = win_q[3];
  assign win_5 = win_q[4];
  assign win_6 = win_q[5];
  assign win_7 = win_q[6];
  assign win_8 = win_q[7];
  assign win_9 = win_q[8];

endmodule

// File: tb/tb_median_window3x3.sv
// Self-checking bench for median_window3x3: table-driven frames checked against
// a spatial reference of the padded image, plus hand-written corner sequences.
module tb_median_window3x3;
  localparam int WIDTH  = 16;
  localparam int DEPTH  = 1920;
  localparam int AWIDTH = 11;
  localparam logic [17:0] PAD = 18'h10000;

  typedef logic [8:0][17:0] win_t;
  typedef struct {
    int w; int h; int gap; int flag; int mult;
    int exp_windows; int exp_ready_low; int hand;
  } cfg_t;
  typedef struct {
    int   idx;
    win_t exp;
  } hand_t;

  logic clk, rst, in_valid, in_sof, in_ready, out_valid, frame_done;
  logic [AWIDTH-1:0] line_width, frame_height;
  logic [17:0] in_data;
  logic [17:0] win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8, win_9;

  median_window3x3 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AWIDTH(AWIDTH)) dut (
    .clk(clk), .rst(rst), .line_width(line_width), .frame_height(frame_height),
    .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .win_1(win_1), .win_2(win_2), .win_3(win_3),
    .win_4(win_4), .win_5(win_5), .win_6(win_6), .win_7(win_7), .win_8(win_8),
    .win_9(win_9), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cur_w = 4, cur_h = 3, cur_mult = 10, cur_flag = 0;
  int cnt = 0, frames_done = 0, last_count = 0;
  bit stepped = 0;
  win_t cap [3840];
  win_t cur_win;

  task automatic chk(input string nm, input logic [161:0] act, input logic [161:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [17:0] pix(int r, int c);
    logic [17:0] v;
    v[15:0]  = 16'(r * cur_mult + c);
    v[17:16] = (cur_flag != 0 && r == 1 && c == 1) ? 2'b10 : 2'b00;
    return v;
  endfunction

  function automatic win_t exp_win(int idx);
    win_t w;
    int rc, cc, rr, c2;
    rc = idx / cur_w;
    cc = idx % cur_w;
    for (int t = 0; t < 9; t++) begin
      rr = rc + t / 3 - 1;
      c2 = cc + t % 3 - 1;
      if (rr < 0 || rr >= cur_h || c2 < 0 || c2 >= cur_w) w[t] = PAD;
      else w[t] = pix(rr, c2);
    end
    return w;
  endfunction

  function automatic win_t mk(logic [17:0] a, logic [17:0] b, logic [17:0] c,
                              logic [17:0] d, logic [17:0] e, logic [17:0] f,
                              logic [17:0] g, logic [17:0] h, logic [17:0] i);
    win_t w;
    w[0] = a; w[1] = b; w[2] = c; w[3] = d; w[4] = e;
    w[5] = f; w[6] = g; w[7] = h; w[8] = i;
    return w;
  endfunction

  // Output monitor: every window against the reference, frame_done placement, gaps.
  always @(negedge clk) begin
    if (out_valid) begin
      cur_win = {win_9, win_8, win_7, win_6, win_5, win_4, win_3, win_2, win_1};
      chk($sformatf("win[%0d]", cnt), cur_win, exp_win(cnt));
      chk($sformatf("frame_done[%0d]", cnt), frame_done, (cnt == cur_w * cur_h - 1));
      chk($sformatf("valid_after_step[%0d]", cnt), stepped, 1'b1);
      if (cnt < 3840) cap[cnt] = cur_win;
      if (frame_done) begin
        frames_done++;
        last_count = cnt + 1;
        cnt = 0;
      end else begin
        cnt++;
      end
    end
    if (rst) cnt = 0;
    stepped = (in_valid && in_ready) || (!in_ready && !rst);
  end

  task automatic run_frame(input int w, input int h, input int gap, input int flag,
                           input int mult, input int npix, output int rl);
    cur_w = w; cur_h = h; cur_flag = flag; cur_mult = mult;
    line_width = AWIDTH'(w);
    frame_height = AWIDTH'(h);
    for (int k = 0; k < npix; k++) begin
      in_valid = 1'b1;
      in_sof   = (k == 0);
      in_data  = pix(k / w, k % w);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      if (gap != 0 && k != npix - 1) repeat (2) begin @(posedge clk); #1; end
    end
    rl = 0;
    if (npix == w * h) begin
      while (!in_ready && rl < 5000) begin
        rl++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic drain();
    repeat (3) begin @(posedge clk); #1; end
  endtask

  cfg_t  cfgs [5];
  hand_t hand [4];
  int    rl, rl2, f0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    cfgs[0] = '{w:4, h:3, gap:0, flag:0, mult:10, exp_windows:12, exp_ready_low:5, hand:1};
    cfgs[1] = '{w:4, h:3, gap:1, flag:0, mult:10, exp_windows:12, exp_ready_low:5, hand:1};
    cfgs[2] = '{w:4, h:3, gap:0, flag:1, mult:10, exp_windows:12, exp_ready_low:5, hand:2};
    cfgs[3] = '{w:5, h:4, gap:1, flag:0, mult:10, exp_windows:20, exp_ready_low:6, hand:0};
    cfgs[4] = '{w:2, h:2, gap:0, flag:0, mult:10, exp_windows:4,  exp_ready_low:3, hand:0};
    hand[0] = '{idx:0,  exp:mk(PAD, PAD, PAD, PAD, 18'd0, 18'd1, PAD, 18'd10, 18'd11)};
    hand[1] = '{idx:5,  exp:mk(18'd0, 18'd1, 18'd2, 18'd10, 18'd11, 18'd12, 18'd20, 18'd21, 18'd22)};
    hand[2] = '{idx:7,  exp:mk(18'd2, 18'd3, PAD, 18'd12, 18'd13, PAD, 18'd22, 18'd23, PAD)};
    hand[3] = '{idx:11, exp:mk(18'd12, 18'd13, PAD, 18'd22, 18'd23, PAD, PAD, PAD, PAD)};

    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    line_width = AWIDTH'(4); frame_height = AWIDTH'(3);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_frame_done", frame_done, 1'b0);
    chk("reset_win", {win_9, win_8, win_7, win_6, win_5, win_4, win_3, win_2, win_1}, '0);
    chk("reset_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 5; i++) begin
      f0 = frames_done;
      run_frame(cfgs[i].w, cfgs[i].h, cfgs[i].gap, cfgs[i].flag, cfgs[i].mult,
                cfgs[i].w * cfgs[i].h, rl);
      drain();
      chk($sformatf("cfg%0d_ready_low", i), rl, cfgs[i].exp_ready_low);
      chk($sformatf("cfg%0d_frames", i), frames_done - f0, 1);
      chk($sformatf("cfg%0d_count", i), last_count, cfgs[i].exp_windows);
      if (cfgs[i].hand == 1) begin
        for (int j = 0; j < 4; j++)
          chk($sformatf("cfg%0d_hand%0d", i, hand[j].idx), cap[hand[j].idx], hand[j].exp);
      end else if (cfgs[i].hand == 2) begin
        chk("flag_win5_c11", cap[5][4], 18'h2000B);
        chk("flag_win9_c00", cap[0][8], 18'h2000B);
        chk("flag_win1_c22", cap[10][0], 18'h2000B);
      end
    end

    // Back-to-back frames: second sof lands on the first cycle in_ready returns.
    f0 = frames_done;
    run_frame(4, 3, 0, 0, 10, 12, rl);
    run_frame(4, 3, 0, 0, 10, 12, rl2);
    drain();
    chk("b2b_ready_low1", rl, 5);
    chk("b2b_ready_low2", rl2, 5);
    chk("b2b_frames", frames_done - f0, 2);
    chk("b2b_count", last_count, 12);
    for (int j = 0; j < 4; j++)
      chk($sformatf("b2b_hand%0d", hand[j].idx), cap[hand[j].idx], hand[j].exp);

    // Reset mid-frame after 6 pixels, then a stray non-sof pixel, then a clean frame.
    f0 = frames_done;
    run_frame(4, 3, 0, 0, 10, 6, rl);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_frame_done", frame_done, 1'b0);
    chk("midrst_win", {win_9, win_8, win_7, win_6, win_5, win_4, win_3, win_2, win_1}, '0);
    rst = 1'b0;
    in_valid = 1'b1; in_sof = 1'b0; in_data = 18'h00055;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("drop_no_valid%0d", k), out_valid, 1'b0);
    end
    in_valid = 1'b0;
    chk("midrst_no_frame", frames_done - f0, 0);
    run_frame(4, 3, 0, 0, 10, 12, rl);
    drain();
    chk("postrst_frames", frames_done - f0, 1);
    chk("postrst_count", last_count, 12);
    for (int j = 0; j < 4; j++)
      chk($sformatf("postrst_hand%0d", hand[j].idx), cap[hand[j].idx], hand[j].exp);

    // Maximum line width.
    f0 = frames_done;
    run_frame(DEPTH, 2, 0, 0, 2048, 2 * DEPTH, rl);
    drain();
    chk("maxw_ready_low", rl, DEPTH + 1);
    chk("maxw_frames", frames_done - f0, 1);
    chk("maxw_count", last_count, 2 * DEPTH);
    chk("maxw_win5", cap[DEPTH-1][4], 18'(DEPTH - 1));
    chk("maxw_win4", cap[DEPTH-1][3], 18'(DEPTH - 2));
    chk("maxw_win8", cap[DEPTH-1][7], 18'(2048 + DEPTH - 1));
    chk("maxw_right", {cap[DEPTH-1][2], cap[DEPTH-1][5], cap[DEPTH-1][8]}, {PAD, PAD, PAD});
    chk("maxw_last_win5", cap[2*DEPTH-1][4], 18'(2048 + DEPTH - 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/median_window3x3.md
# median_window3x3

Streaming 3x3 window generator that sits directly upstream of the 3x3 median filter in the post-processing chain. It accepts a raster-order disparity stream (2-bit flag plus WIDTH-bit data per pixel), buffers two previous lines, and emits nine taps per output pixel in the median filter's `din_1`..`din_9` ordering. Out-of-frame taps are zero-padded and flagged. After the last input pixel, an internal flush emits the final row and column, so exactly W×H windows leave per frame.

## Interface
- WIDTH, 16, data bits per pixel; every pixel bus is WIDTH+2 bits as {flag[1:0], data}.
- DEPTH, 1920, maximum line width in pixels; sets line-buffer depth.
- AWIDTH, 11, column/row counter width; requires 2^AWIDTH > DEPTH.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- line_width  in  AWIDTH  W, pixels per line; legal range 2..DEPTH; sampled when a pixel with in_sof is accepted in IDLE.
- frame_height  in  AWIDTH  H, lines per frame; legal range ≥2; sampled together with line_width.
- in_valid  in  1  input pixel valid.
- in_sof  in  1  marks pixel (0,0); honoured only in IDLE.
- in_data  in  WIDTH+2  input pixel.
- in_ready  out  1  high in IDLE and RUN, low in FLUSH and while rst is high.
- out_valid  out  1  one-cycle strobe; win_* are valid this cycle.
- win_1..win_9  out  WIDTH+2 each  taps. Rows top→bottom are win_1–3 (r-1), win_4–6 (r), win_7–9 (r+1). Within each row, taps run left→right as c-1, c, c+1.
- frame_done  out  1  one-cycle pulse coincident with the last out_valid of a frame.

## Operation
- **State machine:** IDLE, RUN, FLUSH.
  - IDLE → RUN on accept (in_valid & in_ready) with in_sof high. That pixel is (0,0). W and H are latched and counters start.
  - In IDLE, pixels without in_sof are dropped.
  - RUN → FLUSH after pixel (H-1, W-1) is accepted.
  - FLUSH lasts exactly W+1 cycles, one internal step per cycle, with no input accepted. It then returns to IDLE.
- **Input indexing:**
  - Input linear index n = r·W + c, where r and c are the input row and column counters.
  - Flush steps continue the index from W·H to W·H+W.
  - Column counter wraps at W-1 and increments the row counter.
- **Output rule:**
  - Each accepted pixel or flush step with index n ≥ W+1 produces one window.
  - That window is centred on index m = n-W-1, i.e. centre (rc, cc) = (m / W, m % W). Track rc and cc with their own counters; no divider.
  - Steps with n ≤ W produce no output.
- **Storage:**
  - Two line buffers of DEPTH entries, addressed by column. Buffer A holds row r-1 and buffer B holds row r-2 relative to the input row.
  - Three 3-deep column shift registers form the window; each step shifts in the column {bufB, bufA, input}.
  - During flush, the input column is treated as padding.
- **Padding:** each masked tap becomes {2'b01, WIDTH'd0}. Masks are applied on the output register from the centre coordinates:
  - rc == 0 masks the top row.
  - rc == H-1 masks the bottom row.
  - cc == 0 masks the left column.
  - cc == W-1 masks the right column.
- **Flags:** unmasked taps pass flag and data unchanged.
- **Protocol errors:** in_sof seen during RUN is ignored and the pixel is treated as ordinary. Gaps in in_valid stall all counters and shifts.
- **Line-buffer contents** are never cleared; stale data is always covered by the masks.

## Timing
- **Latency:** out_valid and win_* are registered. out_valid rises the cycle after the accept or flush step that produced the window.
- **Throughput:** one window per accepted pixel; no backpressure on the output side.
- **Frame boundaries:**
  - in_ready falls the cycle after pixel (H-1, W-1) is accepted.
  - in_ready rises again the cycle after the last flush step.
  - A new in_sof can be accepted on that cycle, giving back-to-back frames with a W+1 cycle gap.
- **Reset values:** out_valid = 0, frame_done = 0, win_1..win_9 = 0, state = IDLE, all counters = 0.
- **Reset mid-frame:** abort immediately, emit no further windows, and return to IDLE. The next frame must start with in_sof.
- **Line-buffer access:** read and write to the same column happen in one step; read-before-write semantics are required.

## Test plan
- **Basic 4x3 frame:** W=4, H=3, pixel value 10r+c with flags 00, in_valid held high.
  - Exactly 12 out_valid pulses are required.
  - First window: win_1..win_4 = {01,0}, win_5 = 0, win_6 = 1, win_7 = {01,0}, win_8 = 10, win_9 = 11.
  - Last window: win_1..3 = 12, 13, pad; win_4..6 = 22, 23, pad; win_7..9 = pad; frame_done high in the same cycle.
- **Flush handshake:** same frame.
  - in_ready is low for exactly 5 cycles after the 12th accept.
  - A second frame starting immediately after reproduces identical windows.
- **Input gaps:** 4x3 frame with in_valid toggling 1,0,0,1…
  - Window values and count are unchanged; no out_valid occurs during gaps.
- **Flag passthrough:** pixel (1,1) carries flag 2'b10.
  - That value appears unchanged on win_5 for centre (1,1), on win_9 for centre (0,0), and on win_1 for centre (2,2).
- **Reset mid-frame:** assert rst after 6 pixels.
  - Outputs go to 0 the next cycle.
  - A pixel without in_sof is dropped.
  - A new in_sof frame then produces correct windows.
- **Maximum width:** W=DEPTH, H=2, ramp data.
  - 2·DEPTH windows are required.
  - The window centred on column DEPTH-1 has its right column padded, and its win_5 equals the last pixel of the line.
